// File: rtl/snn_load_if.sv
`default_nettype none
// ============================================================================
// Module      : snn_load_if
// Description : Four 4-phase req/ack load channels feeding the SNN NoC top.
// Revision    : 1.0
// ============================================================================
interface snn_load_if #(
  parameter int WIDTH_data = 8,
  parameter int WIDTH_addr = 12,
  parameter int TS_W       = 1
);
  logic                  load_start_req;
  logic                  load_start_ack;
  logic                  filter_req;
  logic                  filter_ack;
  logic [WIDTH_addr-1:0] filter_addr;
  logic [WIDTH_data-1:0] filter_data;
  logic                  ifmap_req;
  logic                  ifmap_ack;
  logic [WIDTH_addr-1:0] ifmap_addr;
  logic                  ifmap_data;
  logic [TS_W-1:0]       ifmap_ts;
  logic                  load_done_req;
  logic                  load_done_ack;

  modport master (
    output load_start_req, filter_req, filter_addr, filter_data,
           ifmap_req, ifmap_addr, ifmap_data, ifmap_ts, load_done_req,
    input  load_start_ack, filter_ack, ifmap_ack, load_done_ack
  );

  modport slave (
    input  load_start_req, filter_req, filter_addr, filter_data,
           ifmap_req, ifmap_addr, ifmap_data, ifmap_ts, load_done_req,
    output load_start_ack, filter_ack, ifmap_ack, load_done_ack
  );
endinterface
`default_nettype wire

// File: rtl/snn_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : snn_load_sequencer
// Description : Host-written filter/ifmap buffers replayed as 4-phase loads.
// Revision    : 1.0
// ============================================================================
module snn_load_sequencer #(
  parameter int WIDTH_data = 8,
  parameter int WIDTH_addr = 12,
  parameter int DEPTH_F    = 5,
  parameter int DEPTH_I    = 25,
  parameter int TIMESTEPS  = 2,
  parameter int SPARSE     = 0,
  localparam int TS_W      = (TIMESTEPS > 1) ? $clog2(TIMESTEPS) : 1
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  input  wire logic                  host_we,
  input  wire logic                  host_sel,
  input  wire logic [TS_W-1:0]       host_ts,
  input  wire logic [WIDTH_addr-1:0] host_addr,
  input  wire logic [WIDTH_data-1:0] host_wdata,
  input  wire logic                  start,
  snn_load_if.master                 lif,
  output logic                       busy,
  output logic                       done
);
  localparam int c_F_WORDS = DEPTH_F * DEPTH_F;
  localparam int c_I_WORDS = DEPTH_I * DEPTH_I;
  localparam int c_I_TOTAL = c_I_WORDS * TIMESTEPS;
  localparam int c_FA_W    = (c_F_WORDS > 1) ? $clog2(c_F_WORDS) : 1;
  localparam int c_IA_W    = (c_I_TOTAL > 1) ? $clog2(c_I_TOTAL) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LS = 3'd1, S_FILT = 3'd2,
    S_IFM  = 3'd3, S_LD = 3'd4, S_FIN  = 3'd5
  } state_t;

  // SETUP fetches the next word (or skips it), REQ holds req until ack=1,
  // REL holds req low until ack returns to 0.
  typedef enum logic [1:0] {
    P_SETUP = 2'd0, P_REQ = 2'd1, P_REL = 2'd2
  } phase_t;

  logic [WIDTH_data-1:0] r_fbuf [c_F_WORDS];
  logic                  r_ibuf [c_I_TOTAL];

  state_t                r_state, w_state;
  phase_t                r_phase, w_phase;
  logic [WIDTH_addr-1:0] r_addr, w_addr;
  logic [TS_W-1:0]       r_ts, w_ts;
  logic                  r_ls_req, w_ls_req, r_f_req, w_f_req;
  logic                  r_i_req, w_i_req, r_ld_req, w_ld_req;
  logic [WIDTH_addr-1:0] r_faddr, w_faddr, r_iaddr, w_iaddr;
  logic [WIDTH_data-1:0] r_fdata, w_fdata;
  logic                  r_idata, w_idata;
  logic [TS_W-1:0]       r_its, w_its;
  logic                  r_busy, w_busy, r_done, w_done;

  logic                  w_host_ok, w_f_wr, w_i_wr;
  logic [c_FA_W-1:0]     w_host_fidx, w_rd_fidx;
  logic [c_IA_W-1:0]     w_host_iidx, w_rd_iidx;
  logic [WIDTH_data-1:0] w_fword;
  logic                  w_spike, w_ack, w_adv;
  logic                  w_last_f, w_last_a, w_last_t;

  assign w_host_ok   = host_we && !r_busy;
  assign w_f_wr      = w_host_ok && !host_sel && (int'(host_addr) < c_F_WORDS);
  assign w_i_wr      = w_host_ok && host_sel && (int'(host_addr) < c_I_WORDS)
                       && (int'(host_ts) < TIMESTEPS);
  assign w_host_fidx = host_addr[c_FA_W-1:0];
  assign w_host_iidx = c_IA_W'(int'(host_ts) * c_I_WORDS + int'(host_addr));

  // Buffers deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_f_wr) r_fbuf[w_host_fidx] <= host_wdata;
    if (w_i_wr) r_ibuf[w_host_iidx] <= host_wdata[0];
  end

  assign w_rd_fidx = r_addr[c_FA_W-1:0];
  assign w_rd_iidx = c_IA_W'(int'(r_ts) * c_I_WORDS + int'(r_addr));
  assign w_fword   = r_fbuf[w_rd_fidx];
  assign w_spike   = r_ibuf[w_rd_iidx];
  assign w_last_f  = (int'(r_addr) == c_F_WORDS - 1);
  assign w_last_a  = (int'(r_addr) == c_I_WORDS - 1);
  assign w_last_t  = (int'(r_ts) == TIMESTEPS - 1);

  always_comb begin
    w_ack = 1'b0;
    case (r_state)
      S_LS:    w_ack = lif.load_start_ack;
      S_FILT:  w_ack = lif.filter_ack;
      S_IFM:   w_ack = lif.ifmap_ack;
      S_LD:    w_ack = lif.load_done_ack;
      default: w_ack = 1'b0;
    endcase
  end

  always_comb begin
    w_state  = r_state;
    w_phase  = r_phase;
    w_addr   = r_addr;
    w_ts     = r_ts;
    w_ls_req = r_ls_req;
    w_f_req  = r_f_req;
    w_i_req  = r_i_req;
    w_ld_req = r_ld_req;
    w_faddr  = r_faddr;
    w_fdata  = r_fdata;
    w_iaddr  = r_iaddr;
    w_idata  = r_idata;
    w_its    = r_its;
    w_busy   = r_busy;
    w_done   = 1'b0;
    w_adv    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state  = S_LS;
          w_phase  = P_REQ;
          w_ls_req = 1'b1;
          w_busy   = 1'b1;
          w_addr   = '0;
          w_ts     = '0;
        end
      end
      S_FIN: begin
        w_state = S_IDLE;
        w_phase = P_SETUP;
      end
      default: begin
        case (r_phase)
          P_SETUP: begin
            case (r_state)
              S_FILT: begin
                w_f_req = 1'b1;
                w_faddr = r_addr;
                w_fdata = w_fword;
                w_phase = P_REQ;
              end
              S_IFM: begin
                if (SPARSE != 0 && !w_spike) begin
                  w_adv = 1'b1;
                end else begin
                  w_i_req = 1'b1;
                  w_iaddr = r_addr;
                  w_idata = w_spike;
                  w_its   = r_ts;
                  w_phase = P_REQ;
                end
              end
              S_LD: begin
                w_ld_req = 1'b1;
                w_phase  = P_REQ;
              end
              default: begin
                w_ls_req = 1'b1;
                w_phase  = P_REQ;
              end
            endcase
          end
          P_REQ: begin
            if (w_ack) begin
              w_ls_req = 1'b0;
              w_f_req  = 1'b0;
              w_i_req  = 1'b0;
              w_ld_req = 1'b0;
              w_phase  = P_REL;
            end
          end
          P_REL: begin
            if (!w_ack) begin
              case (r_state)
                S_LS: begin
                  w_state = S_FILT;
                  w_phase = P_SETUP;
                  w_addr  = '0;
                end
                S_FILT: begin
                  w_phase = P_SETUP;
                  if (w_last_f) begin
                    w_state = S_IFM;
                    w_addr  = '0;
                    w_ts    = '0;
                  end else begin
                    w_addr = r_addr + WIDTH_addr'(1);
                  end
                end
                S_IFM: w_adv = 1'b1;
                S_LD: begin
                  w_state = S_FIN;
                  w_phase = P_SETUP;
                  w_busy  = 1'b0;
                  w_done  = 1'b1;
                end
                default: w_phase = P_SETUP;
              endcase
            end
          end
          default: w_phase = P_SETUP;
        endcase
      end
    endcase
    // Shared ifmap step: used after a completed transfer and after a sparse skip.
    if (w_adv) begin
      w_phase = P_SETUP;
      if (w_last_a) begin
        w_addr = '0;
        if (w_last_t) begin
          w_state = S_LD;
          w_ts    = '0;
        end else begin
          w_ts = r_ts + TS_W'(1);
        end
      end else begin
        w_addr = r_addr + WIDTH_addr'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_phase  <= P_SETUP;
      r_addr   <= '0;
      r_ts     <= '0;
      r_ls_req <= 1'b0;
      r_f_req  <= 1'b0;
      r_i_req  <= 1'b0;
      r_ld_req <= 1'b0;
      r_faddr  <= '0;
      r_fdata  <= '0;
      r_iaddr  <= '0;
      r_idata  <= 1'b0;
      r_its    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_phase  <= w_phase;
      r_addr   <= w_addr;
      r_ts     <= w_ts;
      r_ls_req <= w_ls_req;
      r_f_req  <= w_f_req;
      r_i_req  <= w_i_req;
      r_ld_req <= w_ld_req;
      r_faddr  <= w_faddr;
      r_fdata  <= w_fdata;
      r_iaddr  <= w_iaddr;
      r_idata  <= w_idata;
      r_its    <= w_its;
      r_busy   <= w_busy;
      r_done   <= w_done;
    end
  end

  assign lif.load_start_req = r_ls_req;
  assign lif.filter_req     = r_f_req;
  assign lif.filter_addr    = r_faddr;
  assign lif.filter_data    = r_fdata;
  assign lif.ifmap_req      = r_i_req;
  assign lif.ifmap_addr     = r_iaddr;
  assign lif.ifmap_data     = r_idata;
  assign lif.ifmap_ts       = r_its;
  assign lif.load_done_req  = r_ld_req;
  assign busy               = r_busy;
  assign done               = r_done;
endmodule
`default_nettype wire

// File: tb/tb_snn_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_snn_load_sequencer
// Description : Dense and sparse sequencers checked against a queued model.
// Revision    : 1.0
// ============================================================================
module tb_snn_load_sequencer;
  localparam int NF = 25;
  localparam int NI = 625;
  localparam int NT = 2;

  typedef struct {int ch; int addr; int data; int ts;} xfer_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  host_we_v, start_v;
  logic        host_sel;
  logic        host_ts;
  logic [11:0] host_addr;
  logic [7:0]  host_wdata;

  int    total = 0, bad = 0;
  xfer_t exp_q [2][$];
  int    done_cnt [2];
  int    max_dly;
  bit    stall_en, model_busy;
  int    fmem [NF];
  int    imem [NT][NI];

  logic [3:0]  reqs_o [2];
  logic        busy_o [2], done_o [2];
  logic [11:0] faddr_o [2], iaddr_o [2];

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    snn_load_if #(.WIDTH_data(8), .WIDTH_addr(12), .TS_W(1)) lif ();
    logic busy, done;

    snn_load_sequencer #(
      .WIDTH_data(8), .WIDTH_addr(12), .DEPTH_F(5), .DEPTH_I(25),
      .TIMESTEPS(2), .SPARSE(gi)
    ) dut (
      .clk(clk), .reset(reset), .host_we(host_we_v[gi]), .host_sel(host_sel),
      .host_ts(host_ts), .host_addr(host_addr), .host_wdata(host_wdata),
      .start(start_v[gi]), .lif(lif), .busy(busy), .done(done)
    );

    assign reqs_o[gi]  = {lif.load_done_req, lif.ifmap_req, lif.filter_req, lif.load_start_req};
    assign busy_o[gi]  = busy;
    assign done_o[gi]  = done;
    assign faddr_o[gi] = lif.filter_addr;
    assign iaddr_o[gi] = lif.ifmap_addr;

    // Ack responder: random delay before raising ack, immediate release.
    initial begin
      logic [3:0] ackv;
      int cnt;
      bit armed;
      ackv = '0; cnt = 0; armed = 0;
      {lif.load_done_ack, lif.ifmap_ack, lif.filter_ack, lif.load_start_ack} = '0;
      forever begin
        @(negedge clk);
        if (reset) begin
          ackv = '0;
          armed = 0;
        end else begin
          for (int c = 0; c < 4; c++) begin
            if (!reqs_o[gi][c]) ackv[c] = 1'b0;
            else if (!ackv[c]) begin
              if (!armed) begin
                if (stall_en && gi == 0 && c == 1 && lif.filter_addr == 12'd5) cnt = 7;
                else cnt = int'($urandom_range(max_dly));
                armed = 1;
              end
              if (cnt == 0) begin
                ackv[c] = 1'b1;
                armed = 0;
              end else cnt--;
            end
          end
        end
        {lif.load_done_ack, lif.ifmap_ack, lif.filter_ack, lif.load_start_ack} = ackv;
      end
    end

    // Monitor: pops one expected transfer per req rising edge.
    initial begin
      logic [3:0] prev, cur, rise;
      int pa, pd, pt, cap_a, cap_d, cap_t, ch, hold;
      bit unstable, prev_done;
      xfer_t e;
      prev = '0; unstable = 0; hold = 0; prev_done = 0;
      cap_a = 0; cap_d = 0; cap_t = 0;
      forever begin
        @(negedge clk);
        if (reset) begin
          prev = '0; unstable = 0; hold = 0; prev_done = 0;
        end else begin
          cur  = reqs_o[gi];
          rise = cur & ~prev;
          if (cur[1]) begin
            pa = int'(lif.filter_addr); pd = int'(lif.filter_data); pt = 0;
          end else if (cur[2]) begin
            pa = int'(lif.ifmap_addr); pd = int'(lif.ifmap_data); pt = int'(lif.ifmap_ts);
          end else begin
            pa = 0; pd = 0; pt = 0;
          end
          if (rise != 0) begin
            chk($sformatf("onehot_req[%0d]", gi), $countones(cur), 1);
            chk($sformatf("busy_during_req[%0d]", gi), int'(busy), 1);
            ch = rise[0] ? 0 : rise[1] ? 1 : rise[2] ? 2 : 3;
            if (exp_q[gi].size() == 0) begin
              chk($sformatf("unexpected_xfer[%0d] ch", gi), ch, -1);
            end else begin
              e = exp_q[gi].pop_front();
              chk($sformatf("xfer_ch[%0d]", gi), ch, e.ch);
              chk($sformatf("xfer_addr[%0d] ch%0d", gi, e.ch), pa, e.addr);
              chk($sformatf("xfer_data[%0d] ch%0d a%0d", gi, e.ch, e.addr), pd, e.data);
              chk($sformatf("xfer_ts[%0d] a%0d", gi, e.addr), pt, e.ts);
            end
            cap_a = pa; cap_d = pd; cap_t = pt; hold = 0;
          end
          if ((cur & prev) != 0 && (pa != cap_a || pd != cap_d || pt != cap_t)) unstable = 1;
          if (cur != 0) hold++;
          if ((prev & ~cur) != 0) begin
            chk($sformatf("payload_stable[%0d]", gi), int'(unstable), 0);
            unstable = 0;
            if (stall_en && gi == 0 && prev[1] && cap_a == 5)
              chk("stall_hold_cycles>=8", int'(hold >= 8), 1);
          end
          if (done) begin
            done_cnt[gi]++;
            chk($sformatf("queue_empty_at_done[%0d]", gi), exp_q[gi].size(), 0);
            chk($sformatf("busy_low_at_done[%0d]", gi), int'(busy), 0);
            chk($sformatf("done_single_cycle[%0d]", gi), int'(prev_done), 0);
          end
          prev_done = done;
          prev = cur;
        end
      end
    end
  end

  task automatic build_exp(input int k);
    exp_q[k].delete();
    exp_q[k].push_back('{0, 0, 0, 0});
    for (int a = 0; a < NF; a++) exp_q[k].push_back('{1, a, fmem[a], 0});
    for (int t = 0; t < NT; t++)
      for (int a = 0; a < NI; a++)
        if (k == 0 || imem[t][a] != 0) exp_q[k].push_back('{2, a, imem[t][a], t});
    exp_q[k].push_back('{3, 0, 0, 0});
  endtask

  // Called at a negedge; occupies exactly one write cycle.
  task automatic host_write(input bit sel, input int ts, input int addr, input int data,
                            input logic [1:0] mask);
    host_we_v = mask; host_sel = sel; host_ts = 1'(ts);
    host_addr = 12'(addr); host_wdata = 8'(data);
    if (!model_busy && mask == 2'b11) begin
      if (!sel && addr < NF) fmem[addr] = data & 255;
      if (sel && addr < NI && ts < NT) imem[ts][addr] = data & 1;
    end
    @(negedge clk);
    host_we_v = 2'b00;
  endtask

  task automatic wait_req(input int k, input int bitn, input int addr, input int limit,
                          output bit found);
    found = 0;
    for (int c = 0; c < limit && !found; c++) begin
      @(negedge clk);
      if (reqs_o[k][bitn] && (addr < 0 || int'(faddr_o[k]) == addr)) found = 1;
    end
  endtask

  task automatic do_run(input int mode);
    int cyc;
    bit found;
    build_exp(0);
    build_exp(1);
    done_cnt[0] = 0; done_cnt[1] = 0;
    start_v = 2'b11; model_busy = 1;
    @(negedge clk);
    start_v = 2'b00;
    if (mode == 1) begin
      wait_req(0, 1, -1, 500, found);
      chk("reached_filt_for_write", int'(found), 1);
      host_write(0, 0, 0, 8'hFF, 2'b01);
      wait_req(0, 2, -1, 2000, found);
      chk("reached_ifm_for_restart", int'(found), 1);
      start_v = 2'b01;
      @(negedge clk);
      start_v = 2'b00;
    end
    cyc = 0;
    while ((done_cnt[0] == 0 || done_cnt[1] == 0) && cyc < 40000) begin
      @(negedge clk);
      cyc++;
    end
    chk("run_finished_in_budget", int'(cyc < 40000), 1);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("done_pulses[%0d]", k), done_cnt[k], 1);
      chk($sformatf("busy_idle_after[%0d]", k), int'(busy_o[k]), 0);
    end
    model_busy = 0;
  endtask

  initial begin
    bit found;
    reset = 1'b1; host_we_v = '0; start_v = '0; host_sel = 0; host_ts = 0;
    host_addr = '0; host_wdata = '0; max_dly = 0; stall_en = 0; model_busy = 0;
    done_cnt[0] = 0; done_cnt[1] = 0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_reqs[%0d]", k), int'(reqs_o[k]), 0);
      chk($sformatf("reset_busy[%0d]", k), int'(busy_o[k]), 0);
      chk($sformatf("reset_done[%0d]", k), int'(done_o[k]), 0);
      chk($sformatf("reset_faddr[%0d]", k), int'(faddr_o[k]), 0);
      chk($sformatf("reset_iaddr[%0d]", k), int'(iaddr_o[k]), 0);
    end
    reset = 1'b0;
    @(negedge clk);

    for (int a = 0; a < NF; a++) host_write(0, 0, a, a + 3, 2'b11);
    for (int t = 0; t < NT; t++)
      for (int a = 0; a < NI; a++)
        host_write(1, t, a, (t == 0 && (a == 0 || a == NI - 1)) ? 1 : 0, 2'b11);

    // Abort mid-filter with an asynchronous reset.
    build_exp(0);
    build_exp(1);
    start_v = 2'b11; model_busy = 1;
    @(negedge clk);
    start_v = 2'b00;
    wait_req(0, 1, 10, 500, found);
    chk("reached_filter_addr10", int'(found), 1);
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("abort_reqs[%0d]", k), int'(reqs_o[k]), 0);
      chk($sformatf("abort_busy[%0d]", k), int'(busy_o[k]), 0);
      exp_q[k].delete();
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_busy = 0;
    for (int k = 0; k < 2; k++) chk($sformatf("abort_no_done[%0d]", k), done_cnt[k], 0);
    @(negedge clk);

    max_dly = 0; stall_en = 1;
    do_run(0);
    stall_en = 0;

    max_dly = 2;
    do_run(1);

    host_write(0, 0, 30, 8'h55, 2'b11);
    host_write(1, 0, 700, 1, 2'b11);
    host_write(1, 1, 700, 1, 2'b11);
    do_run(0);

    for (int a = 0; a < NF; a++) host_write(0, 0, a, int'($urandom_range(255)), 2'b11);
    for (int t = 0; t < NT; t++)
      for (int a = 0; a < NI; a++)
        host_write(1, t, a, ($urandom_range(7) == 0) ? 1 : 0, 2'b11);
    for (int n = 0; n < 10; n++)
      host_write(1'($urandom_range(1)), int'($urandom_range(1)),
                 int'($urandom_range(1000)), int'($urandom_range(255)), 2'b11);
    max_dly = 3;
    do_run(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
